muldiv_ctrl: RTL and testbench

Sequencing controller for the multiply/divide resource driven by the ALU's md_a/md_b/mult/md/signed_calc outputs. It accepts one MULT/MULTU/DIV/DIVU request, runs an iterative 1-bit-per-cycle shift-add multiply or restoring divide, and owns the architectural HI/LO registers. It stalls the pipeline while busy, writes HI/LO on completion, and serves MTHI/MTLO writes.

---
 rtl/muldiv_ctrl_pkg.sv | 31 +++
 rtl/muldiv_ctrl_if.sv | 35 +++
 rtl/muldiv_ctrl_md_iter_step.sv | 34 +++
 rtl/muldiv_ctrl.sv | 152 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: state encoding,
// width-independent constants and the md operation-kind encoding.
package muldiv_ctrl_pkg;

    // Sequencer states of the multiply/divide controller.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Default operand width; the iteration count equals the width.
    localparam int ITER_DEFAULT = 32;

    // Quotient written to LO on a divide by zero (sliced to WIDTH by users).
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

    // Operation kind as {mult, signed_calc}, shared with the ALU decode.
    typedef enum logic [1:0] {
        MD_DIVU  = 2'b00,
        MD_DIV   = 2'b01,
        MD_MULTU = 2'b10,
        MD_MULT  = 2'b11
    } md_op_e;

    function automatic md_op_e md_op(input logic mult, input logic signed_calc);
        return md_op_e'({mult, signed_calc});
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle between the pipeline (master) and the
// multiply/divide controller (slave).
interface muldiv_ctrl_if
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = ITER_DEFAULT
);
    logic             md;
    logic             mult;
    logic             signed_calc;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_wdata;
    logic [WIDTH-1:0] lo_wdata;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output md, mult, signed_calc, md_a, md_b, flush,
               hi_we, lo_we, hi_wdata, lo_wdata,
        input  stall, done, div_zero, hi, lo
    );

    modport slave (
        input  md, mult, signed_calc, md_a, md_b, flush,
               hi_we, lo_we, hi_wdata, lo_wdata,
        output stall, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl_md_iter_step.sv
// One iteration of the iterative datapath: a shift-add multiply step or a
// restoring-divide step. For divides the quotient bit is returned separately
// and bit 0 of acc_next is left clear for the controller to fill.
module md_iter_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = ITER_DEFAULT
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mult,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);
    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] rem_diff;

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift right. Divide: shift the remainder
    // left by one dividend bit and subtract if it does not borrow.
    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        rem_diff  = rem_shift - {1'b0, operand};
        q_bit     = ~rem_diff[WIDTH];
        if (mult) begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {(q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: accepts one MULT/MULTU/DIV/DIVU request, runs
// a 1-bit-per-cycle multiply or restoring divide, and owns HI/LO.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = ITER_DEFAULT,
    parameter int ITER  = WIDTH
) (
    input  logic         clk,
    input  logic         resetn,
    muldiv_ctrl_if.slave bus
);
    localparam int            CW       = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    md_state_e          state_reg, state_next;
    md_op_e             op_reg;
    logic [WIDTH-1:0]   a_reg, b_reg, opnd_reg, hi_reg, lo_reg;
    logic [2*WIDTH-1:0] acc_reg, step_acc, prod_fix;
    logic [CW-1:0]      cnt_reg;
    logic               neg_q_reg, neg_r_reg, step_q;
    logic               accept, is_mult, is_signed, a_neg, b_neg, div_zero_fix;
    logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
    logic               stall_next, done_next, div_zero_next;

    assign is_mult      = op_reg[1];
    assign is_signed    = op_reg[0];
    assign accept       = (state_reg == ST_IDLE) & bus.md & ~bus.flush;
    assign a_neg        = is_signed & a_reg[WIDTH-1];
    assign b_neg        = is_signed & b_reg[WIDTH-1];
    assign a_mag        = a_neg ? -a_reg : a_reg;
    assign b_mag        = b_neg ? -b_reg : b_reg;
    assign div_zero_fix = ~is_mult & (opnd_reg == '0);
    assign prod_fix     = neg_q_reg ? -acc_reg : acc_reg;
    assign quot_fix     = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix      = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_reg),
        .operand  (opnd_reg),
        .mult     (is_mult),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    // Next state plus stall/done/div_zero; flush drops stall combinationally.
    always_comb begin
        state_next    = state_reg;
        stall_next    = 1'b0;
        done_next     = 1'b0;
        div_zero_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_PREP;
                    stall_next = 1'b1;
                end
            end
            ST_PREP: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_CALC;
                    stall_next = 1'b1;
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else begin
                    stall_next = 1'b1;
                    if (cnt_reg == CNT_LAST) state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next    = ST_IDLE;
                done_next     = 1'b1;
                div_zero_next = div_zero_fix;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.stall    = stall_next;
    assign bus.done     = done_next;
    assign bus.div_zero = div_zero_next;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;

    // Operand capture, magnitude/sign preparation and iteration datapath.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_reg    <= MD_DIVU;
            a_reg     <= '0;
            b_reg     <= '0;
            opnd_reg  <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg <= md_op(bus.mult, bus.signed_calc);
                        a_reg  <= bus.md_a;
                        b_reg  <= bus.md_b;
                    end
                end
                ST_PREP: begin
                    neg_q_reg <= a_neg ^ b_neg;
                    neg_r_reg <= a_neg;
                    opnd_reg  <= is_mult ? a_mag : b_mag;
                    acc_reg   <= {{WIDTH{1'b0}}, (is_mult ? b_mag : a_mag)};
                    cnt_reg   <= '0;
                end
                ST_CALC: begin
                    acc_reg <= {step_acc[2*WIDTH-1:1], (is_mult ? step_acc[0] : step_q)};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // HI/LO: the computed result owns FIX, MTHI/MTLO write in every other state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state_reg == ST_FIX) begin
            if (is_mult) begin
                {hi_reg, lo_reg} <= prod_fix;
            end else if (div_zero_fix) begin
                hi_reg <= a_reg;
                lo_reg <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
            end else begin
                hi_reg <= rem_fix;
                lo_reg <= quot_fix;
            end
        end else begin
            if (bus.hi_we) hi_reg <= bus.hi_wdata;
            if (bus.lo_we) lo_reg <= bus.lo_wdata;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random
// MULT/MULTU/DIV/DIVU requests against a 64-bit arithmetic reference.
module tb_muldiv_ctrl;
    logic clk;
    logic resetn;
    int   tests;
    int   fails;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    muldiv_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result computed with plain 64-bit arithmetic.
    function automatic void model(input logic m, input logic s,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic ez);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ez = 1'b0;
        if (m) begin
            if (s) begin sp = sa * sb; {eh, el} = sp; end
            else   begin up = ua * ub; {eh, el} = up; end
        end else if (b == 32'd0) begin
            ez = 1'b1;
            el = 32'hFFFF_FFFF;
            eh = a;
        end else if (s) begin
            sq = sa / sb;
            sr = sa % sb;
            el = sq[31:0];
            eh = sr[31:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
    endfunction

    // Issue one request at the current cycle (cycle 0) and follow it to FIX.
    task automatic do_op(input logic m, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input string tag,
                         input bit use_mtlo, input logic [31:0] mtlo_data);
        logic [31:0] eh, el;
        logic        ez;
        int          cyc;
        bit          seen, stall_ok;
        model(m, s, a, b, eh, el, ez);
        bus.md = 1'b1; bus.mult = m; bus.signed_calc = s; bus.md_a = a; bus.md_b = b;
        bus.lo_we = use_mtlo; bus.lo_wdata = mtlo_data;
        cyc = 0; seen = 0; stall_ok = 1;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1;
                check({tag, "_div_zero"}, bus.div_zero, ez);
                check({tag, "_fix_stall"}, bus.stall, 1'b0);
            end else if (bus.stall !== 1'b1) begin
                stall_ok = 0;
            end
            if (use_mtlo && cyc == 5) check({tag, "_mtlo_calc"}, bus.lo, mtlo_data);
            if (!seen) begin
                @(posedge clk); #1;
                bus.md = 1'b0; bus.lo_we = 1'b0;
                cyc++;
            end
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_latency"}, cyc, 34);
        check({tag, "_stall_busy"}, stall_ok, 1'b1);
        @(posedge clk); #1;
        check({tag, "_hi"}, bus.hi, eh);
        check({tag, "_lo"}, bus.lo, el);
        check({tag, "_done_pulse"}, bus.done, 1'b0);
        model_hi = eh;
        model_lo = el;
        $display("[TB] %s mult=%0b signed=%0b a=%h b=%h -> hi=%h lo=%h latency=%0d",
                 tag, m, s, a, b, bus.hi, bus.lo, cyc);
    endtask

    initial begin
        logic [31:0] lo_before, ra, rb;
        logic        rm, rs;
        bit          early_done;
        tests = 0; fails = 0;
        resetn = 1'b0;
        bus.md = 0; bus.mult = 0; bus.signed_calc = 0; bus.md_a = 0; bus.md_b = 0;
        bus.flush = 0; bus.hi_we = 0; bus.lo_we = 0; bus.hi_wdata = 0; bus.lo_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_stall", bus.stall, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_div_zero", bus.div_zero, 1'b0);
        $display("[TB] reset state sampled");
        resetn = 1'b1;
        @(posedge clk); #1;

        do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0, 32'd0);
        do_op(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7", 0, 32'd0);
        do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "div_neg7by2", 0, 32'd0);
        do_op(1'b0, 1'b0, 32'd100, 32'd7, "divu_100by7", 0, 32'd0);
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1", 0, 32'd0);
        do_op(1'b0, 1'b0, 32'h0000_1234, 32'd0, "divu_by_zero", 0, 32'd0);
        do_op(1'b0, 1'b1, 32'hFFFF_FF00, 32'd0, "div_by_zero", 0, 32'd0);

        // MTHI preload, then a MULTU cancelled by flush in cycle 10.
        bus.hi_we = 1'b1; bus.hi_wdata = 32'h0000_AAAA;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        check("mthi_write", bus.hi, 32'h0000_AAAA);
        lo_before = model_lo;
        bus.md = 1'b1; bus.mult = 1'b1; bus.signed_calc = 1'b0; bus.md_a = 32'd5; bus.md_b = 32'd5;
        early_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            bus.md = 1'b0;
            if (c == 10) bus.flush = 1'b1;
            @(negedge clk);
            if (bus.done !== 1'b0) early_done = 1;
        end
        check("flush_stall", bus.stall, 1'b0);
        check("flush_no_done", early_done, 1'b0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_hi", bus.hi, 32'h0000_AAAA);
        check("flush_lo", bus.lo, lo_before);
        $display("[TB] flush of multu 5x5 at cycle 10");
        do_op(1'b0, 1'b0, 32'd1000, 32'd33, "after_flush", 0, 32'd0);

        // Reset asserted at cycle 20 of a DIV.
        bus.hi_we = 1'b1; bus.hi_wdata = 32'h1111; bus.lo_we = 1'b1; bus.lo_wdata = 32'h2222;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.md = 1'b1; bus.mult = 1'b0; bus.signed_calc = 1'b1; bus.md_a = 32'h1000; bus.md_b = 32'd3;
        @(posedge clk); #1;
        bus.md = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("pre_rst_stall", bus.stall, 1'b1);
        resetn = 1'b0;
        #1;
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        check("midrst_stall", bus.stall, 1'b0);
        $display("[TB] reset asserted at cycle 20 of div");
        @(posedge clk); #1;
        resetn = 1'b1;
        do_op(1'b1, 1'b0, 32'd2, 32'd3, "multu_2x3_mtlo", 1, 32'h55);

        // Random requests with occasional zero or small divisors.
        for (int i = 0; i < 16; i++) begin
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 4) rb = 32'd0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            do_op(rm, rs, ra, rb, $sformatf("rand%0d", i), 0, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
